// File: rtl/aes_encrypt_core_pkg.sv
// Shared AES-128 definitions used by the encryption core and by key_expand.
// Contents: round/column counts, FSM state encoding, the FIPS-197 S-box,
// and the GF(2^8) and key-schedule helpers xtime(), rot_word(), rcon().
package aes_encrypt_core_pkg;

  localparam int NR = 10;  // rounds for AES-128
  localparam int NB = 4;   // 32-bit columns per block
  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_APPLY = 3'd3,
    ST_OUT   = 3'd4
  } core_state_e;

  // Entry 0x00 occupies the top byte and entry 0xff the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b); for an 8-bit b, 255-b is ~b.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for key-schedule step i (1..10), placed in the top byte.
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h000000};
  endfunction

endpackage

// File: rtl/aes_encrypt_core_round_comb.sv
// One full AES round, purely combinational:
// SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
// Ports:
//   state_in   in  128  current state, column 0 in bits [127:96]
//   rk         in  128  round key, same layout
//   last_round in  1    1 = omit MixColumns
//   state_out  out 128  next state
// Byte (row r, column c) lives at bits [127-8*(4*c+r) -: 8].
module aes_encrypt_core_round_comb
  import aes_encrypt_core_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0]   sb [4][4];  // [row][col] after SubBytes
  logic [7:0]   sr [4][4];  // [row][col] after ShiftRows
  logic [127:0] shifted;
  logic [127:0] mixed;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      for (gj = 0; gj < 4; gj++) begin : g_row
        // Row r rotates left by r: the output column c takes input column (c+r) mod 4.
        localparam int SRC_COL = (gi + gj) % 4;
        localparam int ROW1    = (gj + 1) % 4;
        localparam int ROW2    = (gj + 2) % 4;
        localparam int ROW3    = (gj + 3) % 4;

        assign sb[gj][gi] = sbox_lookup(state_in[127-8*(4*gi+gj) -: 8]);
        assign sr[gj][gi] = sb[gj][SRC_COL];
        assign shifted[127-8*(4*gi+gj) -: 8] = sr[gj][gi];

        // Row r of the circulant {02,03,01,01}: 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3}.
        assign mixed[127-8*(4*gi+gj) -: 8] =
            xtime(sr[gj][gi]) ^ xtime(sr[ROW1][gi]) ^ sr[ROW1][gi]
            ^ sr[ROW2][gi] ^ sr[ROW3][gi];
      end
    end
  endgenerate

  assign state_out = (last_round ? shifted : mixed) ^ rk;

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core. It loads a block as four words, fetches
// each round key word-serially from key_expand, runs one round every 5 cycles,
// and streams out the ciphertext as four words.
// Ports:
//   clk, reset (async, active-low)
//   start      in   accepted only in IDLE with key_ready=1
//   din        in   32  plaintext word, cycles 1..4 after start, MSW first
//   key_ready  in   round keys valid while high; a falling edge before OUT aborts
//   rk_word    in   32  round key word selected by rk_num/rk_idx in the same cycle
//   rk_num     out  4   round key number; holds outside FETCH
//   rk_idx     out  2   word within round key; holds outside FETCH
//   busy       out  high from the cycle after start through the last output word
//   dout       out  32  ciphertext word, valid with dout_valid (0 otherwise)
//   dout_valid out  4 consecutive cycles, MSW first
//   done       out  pulse with the fourth output word
//   err        out  sticky abort flag, cleared by the next accepted start
module aes_encrypt_core
  import aes_encrypt_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] din,
  input  logic        key_ready,
  input  logic [31:0] rk_word,
  output logic [3:0]  rk_num,
  output logic [1:0]  rk_idx,
  output logic        busy,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        done,
  output logic        err
);

  core_state_e fsm_reg, fsm_next;
  logic [1:0]  phase_reg, phase_next;
  logic [3:0]  rnd_reg, rnd_next;
  logic        err_reg, err_next;
  logic [3:0]  rk_num_reg;
  logic [1:0]  rk_idx_reg;
  logic [31:0] state_reg [NB];
  logic [31:0] rk_reg    [NB];

  logic         load_en, fetch_en, apply_en;
  logic [127:0] state_blk, rk_blk, round_out, apply_blk;
  logic [31:0]  apply_col [NB];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_flat
      assign state_blk[127-32*gi -: 32] = state_reg[gi];
      assign rk_blk[127-32*gi -: 32]    = rk_reg[gi];
      assign apply_col[gi]              = apply_blk[127-32*gi -: 32];
    end
  endgenerate

  aes_encrypt_core_round_comb u_round (
    .state_in   (state_blk),
    .rk         (rk_blk),
    .last_round (rnd_reg == LAST_RND),
    .state_out  (round_out)
  );

  // Round 0 is only the initial AddRoundKey.
  assign apply_blk = (rnd_reg == 4'd0) ? (state_blk ^ rk_blk) : round_out;

  always_comb begin
    fsm_next   = fsm_reg;
    phase_next = phase_reg;
    rnd_next   = rnd_reg;
    err_next   = err_reg;
    load_en    = 1'b0;
    fetch_en   = 1'b0;
    apply_en   = 1'b0;
    busy       = 1'b0;
    dout_valid = 1'b0;
    done       = 1'b0;
    dout       = 32'h0;
    rk_num     = rk_num_reg;
    rk_idx     = rk_idx_reg;

    case (fsm_reg)
      ST_IDLE: begin
        if (start && key_ready) begin
          fsm_next   = ST_LOAD;
          phase_next = 2'd0;
          rnd_next   = 4'd0;
          err_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (!key_ready) begin
          fsm_next   = ST_IDLE;
          err_next   = 1'b1;
          phase_next = 2'd0;
        end else begin
          load_en    = 1'b1;
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd3) fsm_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy   = 1'b1;
        rk_num = rnd_reg;
        rk_idx = phase_reg;
        if (!key_ready) begin
          fsm_next   = ST_IDLE;
          err_next   = 1'b1;
          phase_next = 2'd0;
          rnd_next   = 4'd0;
        end else begin
          fetch_en   = 1'b1;
          phase_next = phase_reg + 2'd1;
          if (phase_reg == 2'd3) fsm_next = ST_APPLY;
        end
      end
      ST_APPLY: begin
        busy = 1'b1;
        if (!key_ready) begin
          fsm_next = ST_IDLE;
          err_next = 1'b1;
          rnd_next = 4'd0;
        end else begin
          apply_en = 1'b1;
          if (rnd_reg == LAST_RND) begin
            rnd_next = 4'd0;
            fsm_next = ST_OUT;
          end else begin
            rnd_next = rnd_reg + 4'd1;
            fsm_next = ST_FETCH;
          end
        end
      end
      ST_OUT: begin
        // The result is already formed, so key_ready is ignored here.
        busy       = 1'b1;
        dout_valid = 1'b1;
        dout       = state_reg[phase_reg];
        phase_next = phase_reg + 2'd1;
        if (phase_reg == 2'd3) begin
          done     = 1'b1;
          fsm_next = ST_IDLE;
        end
      end
      default: begin
        fsm_next   = ST_IDLE;
        phase_next = 2'd0;
        rnd_next   = 4'd0;
      end
    endcase
  end

  assign err = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_reg    <= ST_IDLE;
      phase_reg  <= 2'd0;
      rnd_reg    <= 4'd0;
      err_reg    <= 1'b0;
      rk_num_reg <= 4'd0;
      rk_idx_reg <= 2'd0;
      for (int i = 0; i < NB; i++) begin
        state_reg[i] <= 32'h0;
        rk_reg[i]    <= 32'h0;
      end
    end else begin
      fsm_reg    <= fsm_next;
      phase_reg  <= phase_next;
      rnd_reg    <= rnd_next;
      err_reg    <= err_next;
      rk_num_reg <= rk_num;
      rk_idx_reg <= rk_idx;
      if (load_en) state_reg[phase_reg] <= din;
      if (fetch_en) rk_reg[phase_reg] <= rk_word;
      if (apply_en) begin
        for (int i = 0; i < NB; i++) state_reg[i] <= apply_col[i];
      end
    end
  end

endmodule
